// File: rtl/bk_kbd_ctrl_if.sv
// bk_kbd_ctrl_if: core/ROM side bus of bk_kbd_ctrl; master = keyboard controller (rom_addr, kbd_data, kbd_available, kbd_ar2, stopkey, keydown out; rom_data, read_kbd in), slave = core + lookup ROM
interface bk_kbd_ctrl_if;
  logic [9:0] rom_addr;
  logic [6:0] rom_data;
  logic read_kbd;
  logic [7:0] kbd_data;
  logic kbd_available;
  logic kbd_ar2;
  logic stopkey;
  logic keydown;
  modport master(output rom_addr, kbd_data, kbd_available, kbd_ar2, stopkey, keydown, input rom_data, read_kbd);
  modport slave(input rom_addr, kbd_data, kbd_available, kbd_ar2, stopkey, keydown, output rom_data, read_kbd);
endinterface

// File: rtl/bk_kbd_ctrl.sv
// bk_kbd_ctrl: PS/2 keyboard front end for the BK core (m_clock, async p_reset, ce, raw ps2_clk/ps2_dat, bus = bk_kbd_ctrl_if.master); define KBD_FIFO_EN for a 4-entry FIFO instead of a single-entry register
module bk_kbd_ctrl #(
  parameter int TIMEOUT_CYCLES = 2000
) (
  input logic m_clock,
  input logic p_reset,
  input logic ce,
  input logic ps2_clk,
  input logic ps2_dat,
  bk_kbd_ctrl_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_t;
  rx_t st;
  logic [2:0] ck_s;
  logic [1:0] dt_s;
  logic fall, dat;
  logic [TW-1:0] tmo;
  logic [2:0] nbit;
  logic [7:0] sh, rx_byte;
  logic par, byte_v;
  logic ext, brk, shift, ctrl, ar2, stop_r, kd, look, rk_d;
  logic [2:0] e1_cnt;
  logic [8:0] held;
  logic [9:0] addr;
  logic [6:0] code;
  logic [7:0] ent, head;
  logic push, pop, avail;
  assign fall = ck_s[2] & ~ck_s[1];
  assign dat = dt_s[1];
  always_ff @(posedge m_clock or posedge p_reset)
    if (p_reset) begin
      ck_s <= '0;
      dt_s <= '0;
      st <= IDLE;
      tmo <= '0;
      nbit <= '0;
      sh <= '0;
      par <= 1'b0;
      byte_v <= 1'b0;
      rx_byte <= '0;
    end else if (ce) begin
      ck_s <= {ck_s[1:0], ps2_clk};
      dt_s <= {dt_s[0], ps2_dat};
      byte_v <= 1'b0;
      tmo <= fall ? '0 : (tmo == TW'(TIMEOUT_CYCLES)) ? tmo : tmo + 1'b1;
      if (st != IDLE && !fall && tmo == TW'(TIMEOUT_CYCLES)) st <= IDLE;
      else if (fall)
        case (st)
          IDLE: if (!dat) begin st <= DATA; nbit <= '0; end
          DATA: begin sh <= {dat, sh[7:1]}; nbit <= nbit + 1'b1; if (nbit == 3'd7) st <= PARITY; end
          PARITY: begin par <= dat; st <= STOP; end
          default: begin st <= IDLE; rx_byte <= sh; byte_v <= dat & (^sh ^ par); end
        endcase
    end
  assign code = (ctrl && bus.rom_data[6]) ? (bus.rom_data & 7'o37) : bus.rom_data;
  assign push = look && bus.rom_data != 7'd0;
  assign ent = {code, ar2};
  assign pop = rk_d && !bus.read_kbd && avail;
  always_ff @(posedge m_clock or posedge p_reset)
    if (p_reset) begin
      {ext, brk, shift, ctrl, ar2, stop_r, kd, look, rk_d} <= '0;
      e1_cnt <= '0;
      held <= '0;
      addr <= '0;
    end else if (ce) begin
      rk_d <= bus.read_kbd;
      look <= 1'b0;
      if (byte_v) begin
        if (e1_cnt != 3'd0) e1_cnt <= e1_cnt - 1'b1;
        else if (rx_byte == 8'hE1) e1_cnt <= 3'd7;
        else if (rx_byte == 8'hE0) ext <= 1'b1;
        else if (rx_byte == 8'hF0) brk <= 1'b1;
        else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (rx_byte == 8'h12 || rx_byte == 8'h59) shift <= !brk;
          else if (rx_byte == 8'h14) ctrl <= !brk;
          else if (rx_byte == 8'h11 && !ext) ar2 <= !brk;
          else if (rx_byte == 8'h07) stop_r <= !brk;
          else if (!brk) begin
            addr <= {shift, ext, rx_byte};
            look <= 1'b1;
            kd <= 1'b1;
            held <= {ext, rx_byte};
          end else if (held == {ext, rx_byte}) kd <= 1'b0;
        end
      end
    end
`ifdef KBD_FIFO_EN
  logic [7:0] mem [4];
  logic [1:0] wp, rp;
  logic [2:0] cnt;
  logic wr;
  assign wr = push && (cnt != 3'd4 || pop);
  assign avail = cnt != 3'd0;
  assign head = mem[rp];
  always_ff @(posedge m_clock)
    if (ce && wr) mem[wp] <= ent;
  always_ff @(posedge m_clock or posedge p_reset)
    if (p_reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (ce) begin
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + {2'b0, wr} - {2'b0, pop};
    end
`else
  logic [7:0] q;
  logic full;
  assign avail = full;
  assign head = q;
  always_ff @(posedge m_clock or posedge p_reset)
    if (p_reset) begin
      q <= '0;
      full <= 1'b0;
    end else if (ce) begin
      if (push) q <= ent;
      full <= push || (full && !pop);
    end
`endif
  assign bus.kbd_data = avail ? {1'b0, head[7:1]} : 8'd0;
  assign bus.kbd_ar2 = avail & head[0];
  assign bus.kbd_available = avail;
  assign bus.stopkey = stop_r;
  assign bus.keydown = kd;
  assign bus.rom_addr = addr;
endmodule

// File: doc/bk_kbd_ctrl.md
# bk_kbd_ctrl

PS/2 keyboard front end for the BK core. Receives raw PS/2 frames and tracks E0/F0 prefixes and modifiers. Translates make codes through an external lookup ROM and queues the resulting 7-bit BK key codes. Drives the core's `kbd_data`, `kbd_available`, `kbd_ar2`, `stopkey` and `keydown` inputs, and pops on the core's `read_kbd` decode.

## Interface
- `TIMEOUT_CYCLES`, default 2000: ce-qualified cycles without a PS/2 clock fall before a partial frame is discarded.
- `m_clock`  in  1  system clock. One clock; all state on its rising edge.
- `p_reset`  in  1  reset, asynchronous and active-high.
- `ce`  in  1  clock enable; all state advances only when `ce`=1.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2_dat`  in  1  raw PS/2 data, asynchronous.
- `rom_addr`  out  10  lookup address: {shift, ext, scancode[7:0]}.
- `rom_data`  in  7  BK code from lookup; valid one ce-cycle after `rom_addr`. Value 0 means unmapped.
- `read_kbd`  in  1  core data-register select; level, may stay high several cycles.
- `kbd_data`  out  8  head-of-queue code, bit 7 always 0.
- `kbd_available`  out  1  queue not empty.
- `kbd_ar2`  out  1  AR2 flag stored with the head entry.
- `stopkey`  out  1  STOP key (F12) held.
- `keydown`  out  1  non-modifier key held.

## Operation
- Input sync: `ps2_clk` and `ps2_dat` each pass through 2 flops. A fall is detected on the synchronized clock as previous 1, current 0.
- Frame receiver states:
  - IDLE: a fall with data=0 (start bit) goes to DATA.
  - DATA: 8 falls shift bits in, LSB first, then go to PARITY.
  - PARITY: one fall samples the parity bit, then go to STOP.
  - STOP: a fall with data=1 and odd parity correct delivers the byte. Otherwise the frame is dropped. Either way, return to IDLE.
  - Timeout counter clears on every fall. Reaching `TIMEOUT_CYCLES` outside IDLE forces IDLE with no byte.
- Byte decoder:
  - E0 sets `ext`. F0 sets `brk`. Any other byte is a key event; after it, both flags clear.
  - E1 and its 7 following bytes are swallowed.
- Modifiers (make sets, break clears; none are queued):
  - shift: 12 or 59.
  - ctrl: 14, with or without E0.
  - ar2: 11, without E0.
- STOP: make of 07 sets `stopkey`, break clears it. F12 is not queued.
- Lookup:
  - On a non-modifier make, drive `rom_addr`, wait one ce-cycle, then sample `rom_data`.
  - Nonzero result: if ctrl is held and the code is in 0o100–0o177, AND it with 0o37. Push {code, ar2}.
  - Zero result: discard.
- keydown: set on a non-modifier make; cleared by the break of that same scancode/ext pair, which is held in a 9-bit register.
- Pop: on the falling edge of `read_kbd` (previous 1, current 0) with the queue non-empty. Head data stays stable for the whole access.
- Queue full on push: the new entry is dropped and the queue is unchanged.
- Push and pop in the same cycle: both take effect; the count is unchanged.

## Timing
- Reset values: all outputs 0, `rom_addr`=0, queue empty, receiver IDLE, all flags clear.
- Reset mid-frame or mid-lookup aborts the operation immediately; no entry is pushed.
- Latency from the stop-bit fall to `kbd_available`=1 is 3 ce-cycles:
  - byte delivered;
  - `rom_addr` valid;
  - push.
- `kbd_available` falls in the ce-cycle after the popping `read_kbd` fall, if the queue becomes empty.
- Outputs are registered, with no combinational path from `read_kbd`.

## Configuration
- `KBD_FIFO_EN` defined:
  - Queue is a 4-entry circular FIFO.
  - 2-bit read and write pointers wrap 3→0.
  - 3-bit count.
- `KBD_FIFO_EN` undefined:
  - Queue is a single register.
  - A push while full overwrites the entry (newest wins).
  - Pop empties it.

## Test plan
- Frame 1C (A) with correct parity, `rom_data`=0o101 → after 3 ce-cycles `kbd_data`=0x41, `kbd_available`=1, `keydown`=1. Then F0 1C → `keydown`=0.
- 12, then 1C (`rom_data`=0o141 at address {1,0,0x1C}) with ctrl (14) held → queued code 0o001. Pulse `read_kbd` high for 3 cycles → the pop occurs only after the fall; `kbd_available`=0.
- Left Alt held (11), then 1C → `kbd_ar2`=1 with that entry. Release Alt → the next entry carries `kbd_ar2`=0.
- Bad parity frame, or 4 data bits then silence for `TIMEOUT_CYCLES` → nothing queued; the next valid frame decodes correctly.
- With `KBD_FIFO_EN`: 5 makes without reads → 4 entries held, the 5th dropped, FIFO order kept across pointer wrap. Without it: the last code is held.
- 07 make → `stopkey`=1, nothing queued. `p_reset` asserted mid-frame → all outputs 0 asynchronously.
